// File: rtl/rv32_mod_load_store_unit.sv
// rv32_mod_load_store_unit
//   Load/store unit for the rv32imc_ss core. Accepts one memory op from
//   execute, runs a single naturally-aligned access on the data-memory bus
//   (req/ack handshake) and returns sign/zero-extended load data.
//
// Optional feature macro: RV32_LSU_ALIGN_CHECK_EN
//   defined   : misaligned H/W accesses raise err without a bus access
//   undefined : offsets are truncated to natural alignment, access proceeds
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid / req_ready     op handshake from execute
//   ram_req[2:0], ram_wr      funct3 width/sign, store flag (ram_req[3] unused)
//   addr, wdata               ALU byte address, rs2 store data
//   rd_data, rd_valid         registered load result and its one-cycle strobe
//   done, err                 one-cycle completion / error pulses
//   mem_req/mem_wr/mem_addr/mem_be/mem_wdata   bus request fields
//   mem_ack/mem_rdata/mem_err                  bus response
module rv32_mod_load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  ram_req,
  input  logic        ram_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        unused_ram_req3;
  assign unused_ram_req3 = ram_req[3];

  // Incoming op decode: effective offset, lanes, legality.
  logic [1:0]  in_off;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;
  logic        in_illegal;
  logic        in_misal;

  always_comb begin
    in_off   = 2'b00;
    in_be    = 4'b1111;
    in_wdata = wdata;
    case (ram_req[1:0])
      2'b00: begin
        in_off   = addr[1:0];
        in_be    = 4'b0001 << addr[1:0];
        in_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        in_off   = {addr[1], 1'b0};
        in_be    = addr[1] ? 4'b1100 : 4'b0011;
        in_wdata = {2{wdata[15:0]}};
      end
      default: begin
        in_off   = 2'b00;
        in_be    = 4'b1111;
        in_wdata = wdata;
      end
    endcase

    // Loads: 011/111 (size 11) and 110 are illegal. Stores: only 000/001/010.
    if (ram_wr)
      in_illegal = ram_req[2] || (ram_req[1:0] == 2'b11);
    else
      in_illegal = (ram_req[1:0] == 2'b11) || (ram_req[2:0] == 3'b110);

`ifdef RV32_LSU_ALIGN_CHECK_EN
    in_misal = ((ram_req[1:0] == 2'b01) && addr[0]) ||
               ((ram_req[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    in_misal = 1'b0;
`endif
  end

  // Load extraction from the lane selected by the latched effective offset.
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'h000000, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    f3_d        = f3_q;
    off_d       = off_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d        = ram_wr;
          f3_d        = ram_req[2:0];
          off_d       = in_off;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_be_d    = in_be;
          mem_wdata_d = in_wdata;
          if (in_illegal || in_misal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        if (mem_ack) begin
          err_d   = mem_err;
          state_d = S_RESP;
          // rd_data is written at the ack edge so it is already valid
          // during the rd_valid pulse in RESP.
          if (!mem_err && !wr_q) rd_data_d = load_ext;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign mem_req   = (state_q == S_BUS);
  assign mem_wr    = mem_req && wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = (state_q == S_RESP) && err_q;
  assign done      = (state_q == S_RESP) && !err_q;
  assign rd_valid  = done && !wr_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
// Directed bench for rv32_mod_load_store_unit. A behavioural model computes
// expected bus fields and load results arithmetically; a negedge compare
// process checks every cycle, and literal checks pin the model.
module tb_rv32_mod_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  ram_req;
  logic        ram_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  rv32_mod_load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .ram_req(ram_req), .ram_wr(ram_wr), .addr(addr), .wdata(wdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        cmp_en = 1'b0;
  logic        exp_ready, exp_mreq, exp_err, exp_done, exp_rdv, exp_wr;
  logic [31:0] exp_rd, exp_maddr, exp_mwdata;
  logic [3:0]  exp_be;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic [31:0] lit_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = m_nbytes(f3);
    // natural alignment: round byte offset down to a multiple of size
    return (int'(a[1:0]) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    mask = ((1 << m_nbytes(f3)) - 1) << m_off(f3, a);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    int n;
    n = m_nbytes(f3);
    if (n == 1) return {24'h0, w[7:0]} * 32'h01010101;
    if (n == 2) return {16'h0, w[15:0]} * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [63:0] s, v;
    int nb;
    nb = m_nbytes(f3);
    if (nb == 4) return rd;
    s = {32'h0, rd} >> (8 * m_off(f3, a));
    v = s & ((64'd1 << (8 * nb)) - 64'd1);
    if (!f3[2] && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic m_legal(input logic wr, input logic [2:0] f3);
    if (wr) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic m_misal(input logic [2:0] f3, input logic [31:0] a);
`ifdef RV32_LSU_ALIGN_CHECK_EN
    return (int'(a[1:0]) % m_nbytes(f3)) != 0;
`else
    return (f3 == 3'b111) && (a == 32'h1);  // never true for stimulus used
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("mem_req",   32'(mem_req),   32'(exp_mreq));
      chk("err",       32'(err),       32'(exp_err));
      chk("done",      32'(done),      32'(exp_done));
      chk("rd_valid",  32'(rd_valid),  32'(exp_rdv));
      chk("rd_data",   rd_data,        exp_rd);
      if (exp_mreq) begin
        chk("mem_addr", mem_addr,     exp_maddr);
        chk("mem_be",   32'(mem_be),  32'(exp_be));
        chk("mem_wr",   32'(mem_wr),  32'(exp_wr));
        if (exp_wr) chk("mem_wdata", mem_wdata, exp_mwdata);
        obs_addr  = mem_addr;
        obs_be    = mem_be;
        obs_wdata = mem_wdata;
      end
    end
  end

  task automatic set_idle_exp();
    exp_ready = 1'b1;
    exp_mreq  = 1'b0;
    exp_err   = 1'b0;
    exp_done  = 1'b0;
    exp_rdv   = 1'b0;
  endtask

  // Accept at cycle 0, ack in cycle dly (>=1), pulse at dly+1, idle at dly+2.
  task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] rdata,
                       input int dly, input logic merr);
    logic bad;
    bad = !m_legal(wr, f3) || m_misal(f3, a);
    @(posedge clk); #1;
    req_valid = 1'b1; ram_wr = wr; ram_req = {1'b0, f3}; addr = a; wdata = w;
    set_idle_exp();
    @(posedge clk); #1;
    // scramble op inputs: the unit must work from its latched copy
    req_valid = 1'b0; addr = $urandom; wdata = $urandom;
    ram_req = 4'($urandom_range(0, 15)); ram_wr = 1'($urandom_range(0, 1));
    exp_ready = 1'b0;
    if (bad) begin
      exp_err = 1'b1;
    end else begin
      exp_mreq   = 1'b1;
      exp_maddr  = {a[31:2], 2'b00};
      exp_be     = m_be(f3, a);
      exp_wr     = wr;
      exp_mwdata = m_wdata(f3, w);
      for (int c = 1; c <= dly; c++) begin
        if (c > 1) begin @(posedge clk); #1; end
        mem_ack   = (c == dly);
        mem_rdata = (c == dly) ? rdata : $urandom;
        mem_err   = (c == dly) ? merr : 1'b0;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
      exp_mreq = 1'b0;
      if (merr) exp_err = 1'b1;
      else begin
        exp_done = 1'b1;
        exp_rdv  = !wr;
        if (!wr) exp_rd = m_load(f3, a, rdata);
      end
    end
    @(posedge clk); #1;
    set_idle_exp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; ram_req = '0; ram_wr = 1'b0; addr = '0;
    wdata = '0; mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    exp_rd = '0; exp_wr = 1'b0; exp_be = '0; exp_maddr = '0; exp_mwdata = '0;
    obs_addr = '0; obs_be = '0; obs_wdata = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_wr",    32'(mem_wr),    32'd0);
    chk("rst_pulses",    32'({rd_valid, done, err}), 32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_mem_be",    32'(mem_be), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rd_data",   rd_data,   32'd0);
    set_idle_exp(); exp_ready = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle_exp();

    // SW 0x100, ack two cycles after mem_req rises
    do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 1'b0);
    chk("sw_addr_lit",  obs_addr, 32'h100);
    chk("sw_be_lit",    32'(obs_be), 32'hF);
    chk("sw_wdata_lit", obs_wdata, 32'hDEADBEEF);

    do_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, 1'b0);
    chk("lb_be_lit", 32'(obs_be), 32'h8);
    chk("lb_lit",    rd_data, 32'hFFFFFF80);

    do_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 2, 1'b0);
    chk("lbu_lit", rd_data, 32'h00000080);

    do_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1, 1'b0);
    chk("lh_lit", rd_data, 32'hFFFF8001);

    do_op(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1, 1'b0);
    chk("sh_be_lit",    32'(obs_be), 32'hC);
    chk("sh_wdata_lit", obs_wdata, 32'hABCDABCD);

    do_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1, 1'b0);
`ifdef RV32_LSU_ALIGN_CHECK_EN
    lit_prev = 32'hFFFF8001;
`else
    lit_prev = 32'h11223344;
    chk("lw_mis_addr_lit", obs_addr, 32'h100);
    chk("lw_mis_be_lit",   32'(obs_be), 32'hF);
`endif
    chk("lw_mis_rd_lit", rd_data, lit_prev);

    // bus error: rd_data keeps its previous value
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 32'h55555555, 1, 1'b1);
    chk("lw_buserr_rd_lit", rd_data, lit_prev);

    do_op(1'b0, 3'b011, 32'h204, 32'h0, 32'h0, 1, 1'b0);
    do_op(1'b1, 3'b100, 32'h204, 32'h12345678, 32'h0, 1, 1'b0);
    do_op(1'b0, 3'b110, 32'h204, 32'h0, 32'h0, 1, 1'b0);

    do_op(1'b1, 3'b000, 32'h101, 32'h12345678, 32'h0, 2, 1'b0);
    chk("sb_be_lit",    32'(obs_be), 32'h2);
    chk("sb_wdata_lit", obs_wdata, 32'h78787878);

    do_op(1'b0, 3'b101, 32'h100, 32'h0, 32'h0000F00F, 1, 1'b0);
    chk("lhu_lit", rd_data, 32'h0000F00F);
    do_op(1'b0, 3'b001, 32'h101, 32'h0, 32'h00007F80, 1, 1'b0);
    do_op(1'b0, 3'b000, 32'h102, 32'h0, 32'h00FF0000, 1, 1'b0);

    // ack while idle is ignored
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5; mem_err = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b0;

    // async reset during BUS
    @(posedge clk); #1;
    req_valid = 1'b1; ram_wr = 1'b0; ram_req = 4'b0010; addr = 32'h300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_ready = 1'b0; exp_mreq = 1'b1; exp_maddr = 32'h300; exp_be = 4'hF; exp_wr = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req",   32'(mem_req),   32'd0);
    chk("rst_async_req_ready", 32'(req_ready), 32'd0);
    chk("rst_async_rd_data",   rd_data,        32'd0);
    chk("rst_async_mem_addr",  mem_addr,       32'd0);
    exp_rd = '0;
    set_idle_exp(); exp_ready = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    do_op(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 2, 1'b0);
    chk("post_rst_lw_lit", rd_data, 32'hCAFEF00D);

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
